// File: rtl/liteeth_sram_pkg.sv
// Shared sizes and types for the liteeth SRAM-backed FIFO controller.
// The word and address widths must match the fakeram_1rw1r 12x128 macro.
package liteeth_sram_pkg;

  localparam int BITS       = 12;
  localparam int WORD_DEPTH = 128;
  localparam int ADDR_WIDTH = 7;
  localparam int CNT_W      = ADDR_WIDTH + 1;   // holds 0..WORD_DEPTH
  localparam int LVL_W      = ADDR_WIDTH + 2;   // holds 0..WORD_DEPTH+2

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [BITS-1:0]       word_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [LVL_W-1:0]      lvl_t;

  // WORD_DEPTH is a power of two, so natural overflow gives the modulo wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/liteeth_skid_buf2.sv
// Two-entry output FIFO that absorbs the SRAM read latency.
// Head is held in its own register so out_data is stable while out_ready is low.
module liteeth_skid_buf2
  import liteeth_sram_pkg::*;
#(
  parameter int W = BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         pop;

  assign pop = valid_q & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    valid_d = (cnt_d != 2'd0);
    case (cnt_q)
      2'd0: begin
        if (in_valid) head_d = in_data;
      end
      2'd1: begin
        // With a simultaneous pop the new word becomes the head directly.
        if (in_valid && pop) head_d = in_data;
        else if (in_valid)   tail_d = in_data;
      end
      default: begin
        if (pop) head_d = tail_q;
        if (in_valid) tail_d = in_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign count     = cnt_q;

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// FIFO controller around a 1RW+1R SRAM macro: writes via RW port, reads via R port,
// with a 2-entry output buffer so the 1-cycle read latency does not cost throughput.
module liteeth_sram_fifo_ctrl
  import liteeth_sram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BITS-1:0]       s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  rw0_ce_in,
  output logic                  rw0_we_in,
  output logic [ADDR_WIDTH-1:0] rw0_addr_in,
  output logic [BITS-1:0]       rw0_wd_in,
  output logic                  r0_ce_in,
  output logic [ADDR_WIDTH-1:0] r0_addr_in,
  input  logic [BITS-1:0]       r0_rd_out
);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t sram_cnt_q, sram_cnt_d;
  lvl_t level_q, level_d;
  logic inflight_q, inflight_d;
  logic s_ready_q, s_ready_d;

  logic       push, fetch, pop;
  logic [1:0] buf_cnt;
  logic [2:0] occ, occ_lim;

  // A word becomes fetchable only after its write edge, so the read pointer
  // can only meet the write pointer when the SRAM is full, and then push is blocked.
  always_comb begin
    push    = s_valid & s_ready_q;
    pop     = m_valid & m_ready;
    occ     = {1'b0, buf_cnt} + {2'b00, inflight_q};
    occ_lim = 3'd2 + {2'b00, pop};
    fetch   = (sram_cnt_q != '0) && (occ < occ_lim);

    wr_ptr_d   = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fetch ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    sram_cnt_d = sram_cnt_q + cnt_t'(push) - cnt_t'(fetch);
    inflight_d = fetch;
    level_d    = level_q + lvl_t'(push) - lvl_t'(pop);
    s_ready_d  = (sram_cnt_d < cnt_t'(WORD_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      s_ready_q  <= s_ready_d;
    end
  end

  // Read data returns the cycle after the fetch and lands in the buffer.
  liteeth_skid_buf2 #(.W(BITS)) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_data  (r0_rd_out),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .count    (buf_cnt)
  );

  assign s_ready     = s_ready_q;
  assign level       = level_q;
  assign rw0_ce_in   = push;
  assign rw0_we_in   = push;
  assign rw0_addr_in = wr_ptr_q;
  assign rw0_wd_in   = s_data;
  assign r0_ce_in    = fetch;
  assign r0_addr_in  = rd_ptr_q;

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Bench for liteeth_sram_fifo_ctrl paired with a behavioural fakeram_1rw1r model;
// a queue of accepted words is the reference for order, level and occupancy.
module tb_liteeth_sram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [11:0] m_data;
  logic [8:0]  level;
  logic        rw0_ce_in, rw0_we_in, r0_ce_in;
  logic [6:0]  rw0_addr_in, r0_addr_in;
  logic [11:0] rw0_wd_in;
  logic [11:0] r0_rd_out = '0;

  logic [11:0] ram [0:127];
  logic [11:0] model [$];
  int errors = 0;
  int checks = 0;
  int wr127 = 0;
  int rd127 = 0;

  always #5 clk = ~clk;

  liteeth_sram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in),
    .rw0_addr_in(rw0_addr_in), .rw0_wd_in(rw0_wd_in),
    .r0_ce_in(r0_ce_in), .r0_addr_in(r0_addr_in), .r0_rd_out(r0_rd_out)
  );

  // fakeram_1rw1r: synchronous write on RW port, registered read on R port
  always @(posedge clk) begin
    if (rw0_ce_in && rw0_we_in) ram[rw0_addr_in] <= rw0_wd_in;
    if (r0_ce_in) r0_rd_out <= ram[r0_addr_in];
  end

  // One clock: drive inputs, observe handshakes mid-cycle, update the model.
  task automatic step(input logic sv, input logic [11:0] sd, input logic mr,
                      output logic pushed, output logic popped,
                      output logic [11:0] got, output logic [11:0] exp,
                      output logic exp_ok, output logic coll);
    s_valid = sv; s_data = sd; m_ready = mr;
    @(negedge clk);
    pushed = s_valid & s_ready;
    popped = m_valid & m_ready;
    got    = m_data;
    coll   = rw0_ce_in & r0_ce_in & (rw0_addr_in == r0_addr_in);
    if (rw0_ce_in && rw0_addr_in == 7'd127) wr127++;
    if (r0_ce_in && r0_addr_in == 7'd127) rd127++;
    exp_ok = 1'b1;
    exp    = '0;
    if (popped) begin
      if (model.size() == 0) exp_ok = 1'b0;
      else exp = model.pop_front();
    end
    if (pushed) model.push_back(sd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
    checks++; if (m_data !== 12'h000) begin errors++; $display("FAIL reset_m_data got=%0h want=0", m_data); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%0b want=0", s_ready); end
    checks++; if (level !== 9'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready got=%0b want=1", s_ready); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic pu, po, ok, co;
    logic [11:0] got, exp, hold;
    int v = 1;
    int budget = 0;
    while (v <= 130 && budget < 400) begin
      step(1'b1, 12'(v), 1'b0, pu, po, got, exp, ok, co);
      if (pu) v++;
      budget++;
    end
    checks++; if (v != 131) begin errors++; $display("FAIL fill_count got=%0d want=131", v); end
    checks++; if (int'(level) != 130) begin errors++; $display("FAIL fill_level got=%0d want=130", level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got=%0b want=0", s_ready); end
    hold = m_data;
    step(1'b1, 12'h7FF, 1'b0, pu, po, got, exp, ok, co);
    checks++; if (pu !== 1'b0) begin errors++; $display("FAIL full_push_blocked got=%0b want=0", pu); end
    checks++; if (r0_ce_in !== 1'b0) begin errors++; $display("FAIL full_no_fetch got=%0b want=0", r0_ce_in); end
    checks++; if (m_data !== hold || hold !== 12'h001) begin errors++; $display("FAIL full_m_data_stable got=%0h want=001", m_data); end
    budget = 0;
    while (model.size() > 0 && budget < 400) begin
      step(1'b0, 12'h000, 1'b1, pu, po, got, exp, ok, co);
      if (po) begin
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL drain_order got=%0h want=%0h", got, exp); end
      end
      checks++; if (int'(level) != model.size()) begin errors++; $display("FAIL drain_level got=%0d want=%0d", level, model.size()); end
      budget++;
    end
    checks++; if (model.size() != 0) begin errors++; $display("FAIL drain_timeout got=%0d want=0", model.size()); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b want=0", m_valid); end
    $display("test_fill_drain done, %0d cycles", budget);
  endtask

  task automatic test_stream();
    logic pu, po, ok, co;
    logic [11:0] got, exp;
    int npop = 0;
    int budget = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 12'(i + 16), 1'b1, pu, po, got, exp, ok, co);
      checks++; if (pu !== 1'b1) begin errors++; $display("FAIL stream_push cycle=%0d got=%0b want=1", i, pu); end
      if (i >= 3) begin
        checks++; if (po !== 1'b1) begin errors++; $display("FAIL stream_rate cycle=%0d got=%0b want=1", i, po); end
      end
      if (po) begin
        npop++;
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL stream_order got=%0h want=%0h", got, exp); end
      end
      checks++; if (int'(level) > 3 || int'(level) != model.size()) begin errors++; $display("FAIL stream_level got=%0d want=%0d", level, model.size()); end
    end
    checks++; if (npop != 497) begin errors++; $display("FAIL stream_pops got=%0d want=497", npop); end
    while (model.size() > 0 && budget < 20) begin
      step(1'b0, 12'h000, 1'b1, pu, po, got, exp, ok, co);
      if (po) begin
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL stream_tail got=%0h want=%0h", got, exp); end
      end
      budget++;
    end
    checks++; if (model.size() != 0) begin errors++; $display("FAIL stream_drain got=%0d want=0", model.size()); end
    $display("test_stream done, %0d pops", npop);
  endtask

  task automatic test_random();
    logic pu, po, ok, co, sv;
    logic [11:0] got, exp;
    int n = 0;
    int budget = 0;
    wr127 = 0;
    rd127 = 0;
    while ((n < 300 || model.size() > 0) && budget < 4000) begin
      sv = (n < 300) && ($urandom_range(0, 3) != 0);
      step(sv, 12'($urandom), 1'($urandom_range(0, 1)), pu, po, got, exp, ok, co);
      if (pu) n++;
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL rand_collision addr=%0d got=1 want=0", rw0_addr_in); end
      if (po) begin
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL rand_order got=%0h want=%0h", got, exp); end
      end
      checks++; if (int'(level) != model.size()) begin errors++; $display("FAIL rand_level got=%0d want=%0d", level, model.size()); end
      budget++;
    end
    checks++; if (n != 300 || model.size() != 0) begin errors++; $display("FAIL rand_timeout got=%0d/%0d want=300/0", n, model.size()); end
    checks++; if (wr127 < 2 || rd127 < 2) begin errors++; $display("FAIL rand_wrap got=%0d/%0d want>=2", wr127, rd127); end
    $display("test_random done, %0d cycles", budget);
  endtask

  task automatic test_single();
    logic pu, po, ok, co;
    logic [11:0] got, exp;
    checks++; if (m_valid !== 1'b0 || level !== 9'd0) begin errors++; $display("FAIL single_pre got=%0b/%0d want=0/0", m_valid, level); end
    step(1'b1, 12'hABC, 1'b0, pu, po, got, exp, ok, co);
    checks++; if (pu !== 1'b1) begin errors++; $display("FAIL single_push got=%0b want=1", pu); end
    checks++; if (m_valid !== 1'b0 || int'(level) != 1) begin errors++; $display("FAIL single_n1 got=%0b/%0d want=0/1", m_valid, level); end
    step(1'b0, 12'h000, 1'b0, pu, po, got, exp, ok, co);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_n1_valid got=%0b want=0", m_valid); end
    step(1'b0, 12'h000, 1'b0, pu, po, got, exp, ok, co);
    checks++; if (m_valid !== 1'b1 || m_data !== 12'hABC) begin errors++; $display("FAIL single_n2 got=%0b/%0h want=1/abc", m_valid, m_data); end
    step(1'b0, 12'h000, 1'b0, pu, po, got, exp, ok, co);
    checks++; if (int'(level) != 1 || m_data !== 12'hABC) begin errors++; $display("FAIL single_hold got=%0d/%0h want=1/abc", level, m_data); end
    step(1'b0, 12'h000, 1'b1, pu, po, got, exp, ok, co);
    checks++; if (po !== 1'b1 || got !== 12'hABC) begin errors++; $display("FAIL single_pop got=%0b/%0h want=1/abc", po, got); end
    checks++; if (level !== 9'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL single_after got=%0d/%0b want=0/0", level, m_valid); end
    $display("test_single done");
  endtask

  task automatic test_reset_mid();
    logic pu, po, ok, co;
    logic [11:0] got, exp;
    int n = 0;
    int budget = 0;
    while (n < 57 && budget < 200) begin
      step(1'b1, 12'($urandom), 1'b0, pu, po, got, exp, ok, co);
      if (pu) n++;
      budget++;
    end
    checks++; if (int'(level) != 57) begin errors++; $display("FAIL mid_level got=%0d want=57", level); end
    s_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (level !== 9'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL mid_async got=%0d/%0b want=0/0", level, m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready_low got=%0b want=0", s_ready); end
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready_release got=%0b want=1", s_ready); end
    step(1'b1, 12'h5A5, 1'b0, pu, po, got, exp, ok, co);
    checks++; if (pu !== 1'b1) begin errors++; $display("FAIL mid_push got=%0b want=1", pu); end
    budget = 0;
    po = 1'b0;
    while (!po && budget < 10) begin
      step(1'b0, 12'h000, 1'b1, pu, po, got, exp, ok, co);
      budget++;
    end
    checks++; if (!po || got !== 12'h5A5) begin errors++; $display("FAIL mid_first_word got=%0h want=5a5", got); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_random();
    test_single();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
